// File: rtl/duty_gen_if.sv
// Control/status bundle for duty_gen: pending-setting load port plus the generated waveform.
interface duty_gen_if #(
    parameter int CNT_W = 10
);
    logic             load;
    logic [CNT_W-1:0] period_in;
    logic [CNT_W-1:0] high_in;
    logic             ft;
    logic             cyc_start;
    logic             pend;

    modport master (
        output load, period_in, high_in,
        input  ft, cyc_start, pend
    );

    modport slave (
        input  load, period_in, high_in,
        output ft, cyc_start, pend
    );
endinterface

// File: rtl/duty_gen.sv
// Programmable PWM test-signal generator with double-buffered period/high settings.
// Optional `DUTY_SWEEP_EN: high time steps by one tick per period when nothing is pending.
module duty_gen #(
    parameter int CNT_W    = 10,
    parameter int DIV      = 1,
    parameter int PER_RST  = 10,
    parameter int HIGH_RST = 5
) (
    input  logic     inclk0,
    input  logic     rst_n,
    duty_gen_if.slave bus
);

    localparam int                 PRE_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [CNT_W-1:0]   PER_INIT  = CNT_W'(PER_RST);
    localparam logic [CNT_W-1:0]   HIGH_INIT = CNT_W'(HIGH_RST);
    localparam logic [CNT_W-1:0]   PER_MIN   = CNT_W'(2);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0] ph_q, ph_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] pend_per_q, pend_per_d;
    logic [CNT_W-1:0] pend_high_q, pend_high_d;
    logic             pend_q, pend_d;
    logic             ft_q, ft_d;
    logic             cyc_start_q, cyc_start_d;
    logic             tick;
    logic             wrap;

`ifdef DUTY_SWEEP_EN
    logic [CNT_W:0]   high_inc;
    logic [CNT_W-1:0] high_sweep;

    always_comb begin
        high_inc   = {1'b0, high_q} + 1'b1;
        high_sweep = (high_inc >= {1'b0, per_q}) ? '0 : high_inc[CNT_W-1:0];
    end
`endif

    always_comb begin
        tick      = (pre_cnt_q == PRE_LAST);
        pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;

        wrap = tick && (ph_q == per_q - 1'b1);
        ph_d = ph_q;
        if (tick) begin
            ph_d = wrap ? '0 : ph_q + 1'b1;
        end

        cyc_start_d = wrap;
        ft_d        = (ph_q < high_q);

        per_d       = per_q;
        high_d      = high_q;
        pend_per_d  = pend_per_q;
        pend_high_d = pend_high_q;
        pend_d      = pend_q;

        // Apply uses the pending set held before this edge; a coincident load
        // is evaluated afterwards so it stays pending for the next wrap.
        if (wrap) begin
            if (pend_q) begin
                per_d  = pend_per_q;
                high_d = pend_high_q;
                pend_d = 1'b0;
            end
`ifdef DUTY_SWEEP_EN
            else begin
                high_d = high_sweep;
            end
`endif
        end

        if (bus.load) begin
            pend_per_d  = (bus.period_in < PER_MIN) ? PER_MIN : bus.period_in;
            pend_high_d = bus.high_in;
            pend_d      = 1'b1;
        end
    end

    always_ff @(posedge inclk0 or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q   <= '0;
            ph_q        <= '0;
            per_q       <= PER_INIT;
            high_q      <= HIGH_INIT;
            pend_per_q  <= PER_INIT;
            pend_high_q <= HIGH_INIT;
            pend_q      <= 1'b0;
            ft_q        <= 1'b0;
            cyc_start_q <= 1'b0;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            ph_q        <= ph_d;
            per_q       <= per_d;
            high_q      <= high_d;
            pend_per_q  <= pend_per_d;
            pend_high_q <= pend_high_d;
            pend_q      <= pend_d;
            ft_q        <= ft_d;
            cyc_start_q <= cyc_start_d;
        end
    end

    assign bus.ft        = ft_q;
    assign bus.cyc_start = cyc_start_q;
    assign bus.pend      = pend_q;

endmodule
